// File: rtl/regdst_wb_ctrl_if.sv
// Writeback control bus between the main control FSM / memory and the
// register-destination writeback sequencer.
interface regdst_wb_ctrl_if;
    logic       start;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic [2:0] RegDst;
    logic       RegWrite;
    logic [1:0] MemtoReg;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, opcode, funct, mem_ready,
        input  RegDst, RegWrite, MemtoReg, busy, done, err
    );

    modport slave (
        input  start, opcode, funct, mem_ready,
        output RegDst, RegWrite, MemtoReg, busy, done, err
    );
endinterface

// File: rtl/regdst_wb_ctrl.sv
// Writeback sequencer: decodes opcode/funct on start, waits for memory on
// loads, issues one or two register writes, then reports done/err.
module regdst_wb_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    regdst_wb_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = 8;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DECODE   = 3'd1;
    localparam logic [2:0] S_WAIT_MEM = 3'd2;
    localparam logic [2:0] S_WRITE1   = 3'd3;
    localparam logic [2:0] S_WRITE2   = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [5:0]       fn_q, fn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [2:0]       regdst_q, regdst_d;
    logic             regwrite_q, regwrite_d;
    logic [1:0]       memtoreg_q, memtoreg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             writes_c, needs_mem_c, pop_c;
    logic [2:0]       dst_c;
    logic [1:0]       m2r_c;

    // Instruction class decode from the latched opcode/funct
    always_comb begin
        writes_c    = 1'b1;
        needs_mem_c = 1'b0;
        pop_c       = 1'b0;
        dst_c       = 3'b000;
        m2r_c       = 2'b00;
        case (op_q)
            6'h00: begin
                if (fn_q == 6'h08) writes_c = 1'b0;
                else               dst_c    = 3'b001;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: ;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                needs_mem_c = 1'b1;
                m2r_c       = 2'b01;
            end
            6'h03: begin
                dst_c = 3'b011;
                m2r_c = 2'b10;
            end
            6'h3F: begin
                dst_c = 3'b010;
                m2r_c = 2'b11;
            end
            6'h3E: begin
                needs_mem_c = 1'b1;
                pop_c       = 1'b1;
                m2r_c       = 2'b01;
            end
            default: writes_c = 1'b0;
        endcase
    end

    // Next state, and outputs registered from the next state
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        fn_d       = fn_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        regdst_d   = 3'b000;
        regwrite_d = 1'b0;
        memtoreg_d = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d      = bus.opcode;
                    fn_d      = bus.funct;
                    timeout_d = 1'b0;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!writes_c) begin
                    state_d = S_DONE;
                end else if (needs_mem_c) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_MEM;
                end else begin
                    state_d = S_WRITE1;
                end
            end
            S_WAIT_MEM: begin
                // mem_ready wins over a timeout seen in the same cycle
                if (bus.mem_ready) begin
                    state_d = S_WRITE1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            S_WRITE1: state_d = pop_c ? S_WRITE2 : S_DONE;
            S_WRITE2: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (state_d == S_WRITE1) begin
            regwrite_d = 1'b1;
            regdst_d   = dst_c;
            memtoreg_d = m2r_c;
        end else if (state_d == S_WRITE2) begin
            regwrite_d = 1'b1;
            regdst_d   = 3'b010;
            memtoreg_d = 2'b11;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_DONE) && timeout_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            fn_q       <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            regdst_q   <= 3'b000;
            regwrite_q <= 1'b0;
            memtoreg_q <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            fn_q       <= fn_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            regdst_q   <= regdst_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.RegDst   = regdst_q;
    assign bus.RegWrite = regwrite_q;
    assign bus.MemtoReg = memtoreg_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_regdst_wb_ctrl.sv
// Directed bench for regdst_wb_ctrl: per-cycle output log per transaction,
// checked against hand-computed cycle-exact expectations.
module tb_regdst_wb_ctrl;
    localparam int unsigned NLOG = 24;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   n_wr;
    int   n_dn;
    logic [8:0] snap_log [NLOG];

    regdst_wb_ctrl_if bus ();

    regdst_wb_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {RegDst[2:0], RegWrite, MemtoReg[1:0], busy, done, err}
    function automatic logic [8:0] snap();
        return {bus.RegDst, bus.RegWrite, bus.MemtoReg, bus.busy, bus.done, bus.err};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle c = interval after the c-th posedge; start is driven in cycles 0..hold.
    task automatic run(input logic [5:0] op, input logic [5:0] fn,
                       input int rdy_at, input int hold);
        n_wr = 0;
        n_dn = 0;
        for (int c = 0; c < int'(NLOG); c++) begin
            bus.start     = (c <= hold);
            bus.opcode    = op;
            bus.funct     = fn;
            bus.mem_ready = (c == rdy_at);
            snap_log[c]   = snap();
            if (bus.RegWrite) n_wr++;
            if (bus.done)     n_dn++;
            tick();
        end
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    // {RegDst, RegWrite, MemtoReg} of a logged cycle
    function automatic logic [5:0] wfield(input int c);
        logic [8:0] s;
        s = snap_log[c];
        return s[8:3];
    endfunction

    function automatic logic [2:0] sfield(input int c);
        logic [8:0] s;
        s = snap_log[c];
        return s[2:0];
    endfunction

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.opcode    = '0;
        bus.funct     = '0;
        bus.mem_ready = 1'b0;
        #2;
        check("reset_outputs", 32'(snap()), 32'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // addu: write rd / ALU at cycle 2, done at 3
        run(6'h00, 6'h21, -1, 0);
        check("addu_busy_c1", 32'(sfield(1)), 32'b100);
        check("addu_write_c2", 32'(wfield(2)), 32'b001_1_00);
        check("addu_done_c3", 32'(sfield(3)), 32'b110);
        check("addu_idle_c4", 32'(snap_log[4]), 32'h0);
        check("addu_nwr", 32'(n_wr), 32'd1);

        // lw, mem_ready at cycle 5
        run(6'h23, 6'h00, 5, 0);
        check("lw_nowrite_c5", 32'(wfield(5)), 32'b000_0_00);
        check("lw_write_c6", 32'(wfield(6)), 32'b000_1_01);
        check("lw_done_c7", 32'(sfield(7)), 32'b110);
        check("lw_nwr", 32'(n_wr), 32'd1);

        // lw timeout: WAIT_MEM cycles 2..16, done+err at 17
        run(6'h23, 6'h00, -1, 0);
        check("to_nwr", 32'(n_wr), 32'd0);
        check("to_wait_c16", 32'(sfield(16)), 32'b100);
        check("to_done_c17", 32'(sfield(17)), 32'b111);
        check("to_idle_c18", 32'(snap_log[18]), 32'h0);

        // mem_ready on the last WAIT_MEM cycle beats the timeout
        run(6'h20, 6'h00, 16, 0);
        check("pri_write_c17", 32'(wfield(17)), 32'b000_1_01);
        check("pri_done_c18", 32'(sfield(18)), 32'b110);

        // pop: two writes
        run(6'h3E, 6'h00, 2, 0);
        check("pop_w1_c3", 32'(wfield(3)), 32'b000_1_01);
        check("pop_w2_c4", 32'(wfield(4)), 32'b010_1_11);
        check("pop_done_c5", 32'(sfield(5)), 32'b110);
        check("pop_nwr", 32'(n_wr), 32'd2);

        // jal, push, addi
        run(6'h03, 6'h00, -1, 0);
        check("jal_write_c2", 32'(wfield(2)), 32'b011_1_10);
        check("jal_done_c3", 32'(sfield(3)), 32'b110);
        run(6'h3F, 6'h00, -1, 0);
        check("push_write_c2", 32'(wfield(2)), 32'b010_1_11);
        run(6'h08, 6'h00, -1, 0);
        check("addi_write_c2", 32'(wfield(2)), 32'b000_1_00);

        // sw and jr: no write, done at cycle 2
        run(6'h2B, 6'h00, -1, 0);
        check("sw_nwr", 32'(n_wr), 32'd0);
        check("sw_done_c2", 32'(sfield(2)), 32'b110);
        run(6'h00, 6'h08, -1, 0);
        check("jr_nwr", 32'(n_wr), 32'd0);
        check("jr_done_c2", 32'(sfield(2)), 32'b110);

        // start held through the transaction: exactly one write and one done
        run(6'h00, 6'h21, -1, 3);
        check("rep_nwr", 32'(n_wr), 32'd1);
        check("rep_ndn", 32'(n_dn), 32'd1);

        // reset in the middle of WRITE1
        bus.start  = 1'b1;
        bus.opcode = 6'h00;
        bus.funct  = 6'h21;
        tick();
        bus.start = 1'b0;
        tick();
        check("rst_pre_write", 32'(bus.RegWrite), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_outputs", 32'(snap()), 32'h0);
        #1;
        reset = 1'b1;
        n_dn = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.done || bus.RegWrite || bus.busy) n_dn++;
        end
        check("rst_stays_idle", 32'(n_dn), 32'd0);

        // block accepts a fresh start after reset
        run(6'h03, 6'h00, -1, 0);
        check("post_rst_jal", 32'(wfield(2)), 32'b011_1_10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
